// File: rtl/fp_add_normalizer.sv
// Post-ALU normalizer for the single-precision FP adder.
// Takes the raw ALU mantissa and carry and normalizes them, one bit per cycle
// for left shifts. It emits a packed {sign, exp, fraction} with truncation rounding.
module fp_add_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W-1:0]         in_mant,
  input  logic                      in_carry,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic                      in_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   out_result,
  output logic                      out_zero,
  output logic                      out_ovf
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int RES_W  = EXP_W + MANT_W;

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  // Exponent arithmetic runs one bit wider so the carry increment cannot wrap
  logic [EXP_W:0]     exp_in_ext;
  logic [EXP_W:0]     exp_inc;
  logic [EXP_W-1:0]   in_exp_field;
  logic [EXP_W-1:0]   norm_exp_field;
  logic               norm_shift;

  assign exp_in_ext     = {1'b0, in_exp};
  assign exp_inc        = exp_in_ext + EXP_ONE;
  // A clear hidden bit after normalization means subnormal: exponent field 0
  assign in_exp_field   = in_mant[MANT_W-1] ? in_exp : {EXP_W{1'b0}};
  assign norm_exp_field = mant_q[MANT_W-1] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}};
  // Keep shifting left while the hidden bit is clear and the exponent is above the floor
  assign norm_shift     = !mant_q[MANT_W-1] && (exp_q > EXP_ONE);

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: classify on accept, shift in NORM, hold in DONE
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d = in_mant;
          exp_d  = exp_in_ext;
          sign_d = in_sign;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          if (in_exp == {EXP_W{1'b1}}) begin
            // Inf/NaN operand passes straight through
            result_d = {in_sign, in_exp, in_mant[FRAC_W-1:0]};
            state_d  = DONE;
          end else if (in_carry) begin
            mant_d = {1'b1, in_mant[MANT_W-1:1]};
            exp_d  = exp_inc;
            if (exp_inc == EXP_MAX) begin
              result_d = {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              ovf_d    = 1'b1;
            end else begin
              result_d = {in_sign, exp_inc[EXP_W-1:0], in_mant[MANT_W-1:1]};
            end
            state_d = DONE;
          end else if (in_mant == '0) begin
            // Exact cancellation always yields +0
            result_d = '0;
            sign_d   = 1'b0;
            zero_d   = 1'b1;
            state_d  = DONE;
          end else if (in_mant[MANT_W-1] || (exp_in_ext <= EXP_ONE)) begin
            result_d = {in_sign, in_exp_field, in_mant[FRAC_W-1:0]};
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (norm_shift) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end else begin
          result_d = {sign_q, norm_exp_field, mant_q[FRAC_W-1:0]};
          state_d  = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Self-checking bench for fp_add_normalizer: directed cases plus random
// transactions compared against a leading-one based reference model.
module tb_fp_add_normalizer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  fp_add_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_carry   (in_carry),
    .in_exp     (in_exp),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, expv);
    end
  endtask

  // Reference: find the leading one, shift it to the hidden position unless the
  // exponent floor of 1 stops it first. Latency counts edges including accept.
  function automatic void model(input logic [23:0] m, input logic c, input logic [7:0] e,
                                input logic s, output logic [31:0] res, output logic z,
                                output logic o, output int lat);
    int p, k, lim, ef;
    logic [23:0] m2;
    logic [7:0]  e2;
    z = 1'b0; o = 1'b0; lat = 1;
    if (e == 8'd255) begin
      res = {s, 8'hFF, m[22:0]};
    end else if (c) begin
      ef = int'(e) + 1;
      if (ef == 255) begin
        res = {s, 8'hFF, 23'd0};
        o = 1'b1;
      end else begin
        e2 = 8'(ef);
        res = {s, e2, m[23:1]};
      end
    end else if (m == 24'd0) begin
      res = 32'd0;
      z = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      k = 23 - p;
      lim = (e > 8'd1) ? int'(e) - 1 : 0;
      if (k > lim) k = lim;
      m2 = m << k;
      e2 = 8'(int'(e) - k);
      res = {s, (m2[23] ? e2 : 8'd0), m2[22:0]};
      lat = (k == 0) ? 1 : k + 2;
    end
  endfunction

  task automatic run(input logic [23:0] m, input logic c, input logic [7:0] e,
                     input logic s, input int hold, input string tag);
    logic [31:0] eres;
    logic ez, eo;
    int elat, lat, n;
    model(m, c, e, s, eres, ez, eo, elat);
    @(negedge CLK);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "/ready"}, 32'(in_ready), 32'd1);
    in_mant = m; in_carry = c; in_exp = e; in_sign = s; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, "/lat"}, 32'(lat), 32'(elat));
    chk({tag, "/res"}, out_result, eres);
    chk({tag, "/zero"}, 32'(out_zero), 32'(ez));
    chk({tag, "/ovf"}, 32'(out_ovf), 32'(eo));
    chk({tag, "/busy"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk({tag, "/hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "/hold_r"}, out_result, eres);
      chk({tag, "/hold_rdy"}, 32'(in_ready), 32'd0);
    end
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    chk({tag, "/drain_v"}, 32'(out_valid), 32'd0);
    chk({tag, "/drain_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "/drain_f"}, {30'd0, out_zero, out_ovf}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    run(24'h000000, 1'b1, 8'd127, 1'b0, 0, "one_plus_one");
    chk("t1_const", out_result, 32'h40000000);
    run(24'h200000, 1'b0, 8'd127, 1'b0, 0, "sub_norm");
    chk("t2_const", out_result, 32'h3E800000);
    run(24'h000000, 1'b0, 8'd130, 1'b1, 0, "cancel");
    chk("t3_const", out_result, 32'h00000000);
    run(24'h000000, 1'b1, 8'd254, 1'b1, 0, "overflow");
    chk("t4_const", out_result, 32'hFF800000);
    run(24'h000100, 1'b0, 8'd3, 1'b0, 5, "subnormal");
    chk("t5_const", out_result, 32'h00000400);
    run(24'h400000, 1'b0, 8'd255, 1'b1, 0, "nan_pass");

    // Reset during NORM after the first shift edge
    @(negedge CLK);
    in_mant = 24'h200000; in_carry = 1'b0; in_exp = 8'd127; in_sign = 1'b0; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res", out_result, 32'd0);
    chk("mid_rst_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    run(24'h000000, 1'b1, 8'd127, 1'b0, 0, "after_rst");

    for (int t = 0; t < 60; t++) begin
      logic [23:0] m;
      logic [7:0]  e;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'd0;
        1: e = 8'd1;
        2: e = 8'd2;
        3: e = 8'd254;
        4: e = 8'd255;
        default: e = 8'($urandom_range(0, 255));
      endcase
      m = 24'($urandom) >> $urandom_range(0, 24);
      run(m, ($urandom_range(0, 3) == 0), e, 1'($urandom), $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Post-ALU stage of the single-precision floating-point adder.
- Consumes the ALU's 24-bit raw mantissa result and carry, plus the large-operand exponent and result sign.
- Normalizes iteratively: right-shifts once on carry, otherwise left-shifts one bit per cycle until the hidden bit is set or the exponent floor is reached.
- Emits a packed IEEE-754 single with valid/ready handshakes on both sides; rounding is truncation.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, exponent field width.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream ALU result valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_mant  input  MANT_W  ALU result.
- in_carry  input  1  ALU carry-out.
- in_exp  input  EXP_W  large-operand biased exponent.
- in_sign  input  1  sign of large operand (result sign).
- out_valid  output  1  out_result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  1+EXP_W+MANT_W-1  {sign, exp, fraction}.
- out_zero  output  1  result is exact zero.
- out_ovf  output  1  exponent overflow (infinity produced).

Behaviour:
- Reset (RST low, async):
  - state=IDLE.
  - out_valid, out_result, out_zero, out_ovf, and internal mant/exp/sign registers = 0.
  - in_ready is combinational (state==IDLE), so it reads 1 during reset; no capture occurs while RST is low.
- States: IDLE, NORM, DONE.
- Accept: rising edge with in_valid && in_ready. Inputs are latched and classified in the same edge, in priority order:
  1. in_exp==255: pass through (inf/NaN). exp=255, fraction=in_mant[22:0], sign=in_sign. Go to DONE.
  2. in_carry==1: mant={1,in_mant[23:1]}, exp=in_exp+1.
     - If in_exp+1==255: fraction=0, out_ovf=1 (infinity, sign kept).
     - Go to DONE in either case.
  3. in_carry==0 && in_mant==0: out_result=0x00000000 (+0, sign forced 0), out_zero=1. Go to DONE.
  4. in_mant[23]==1, or in_exp<=1: no shift needed. Exp field = in_mant[23] ? in_exp : 0 (subnormal). Go to DONE.
  5. Otherwise go to NORM.
- NORM, each cycle:
  - If mant[23]==0 && exp>1: mant<<=1 (zero fill), exp-=1.
  - Else: pack {sign, mant[23]?exp:0, mant[22:0]} and go to DONE.
  - Shift count ≤ 23; bits shifted out on the right (carry case) are discarded.
- DONE:
  - out_valid=1; out_result/out_zero/out_ovf held stable.
  - Edge with out_ready=1: out_valid=0, flags cleared, state=IDLE.
  - No new accept until the following IDLE cycle.
- Latency (accept edge to out_valid high):
  - Cases 1–4: 1 cycle.
  - k left shifts: k+2 cycles (k shift edges plus one pack edge).
- Exponent arithmetic is EXP_W+1 bits internally; overflow is checked only on the carry path, and underflow is prevented by the exp>1 floor.
- Reset mid-operation aborts immediately. The pending result is lost and out_valid drops asynchronously.
- in_valid while not IDLE is ignored; upstream must hold data until in_ready.

Test Plan:
1. 1.0+1.0: in_mant=0x000000, carry=1, exp=127, sign=0 -> out_result=0x40000000 one cycle after accept, flags 0.
2. 1.5−1.25: in_mant=0x200000, carry=0, exp=127 -> 2 shifts, out_result=0x3E800000 (0.25) exactly 4 cycles after accept.
3. Exact cancel: in_mant=0, carry=0, exp=130, sign=1 -> out_result=0x00000000, out_zero=1, 1-cycle latency.
4. Overflow: carry=1, in_mant=0x000000, exp=254, sign=1 -> out_result=0xFF800000, out_ovf=1.
5. Subnormal floor: in_mant=0x000100, carry=0, exp=3 -> shifts stop at exp=1, out_result=0x00000400; also hold out_ready=0 for 5 cycles -> out_valid and data stable, in_ready=0 throughout, IDLE one edge after out_ready=1.
6. Reset mid-NORM: start case 2, pull RST low after first shift edge -> all outputs 0 immediately, in_ready=1 after release, next transaction (case 1) correct.
